sha_stream: RTL and testbench

Byte-stream front end for the SHA core. It accepts a message one byte at a time over a valid/ready handshake and packs the bytes into an Nl-byte buffer. It then issues a single start pulse to the SHA core and waits for the core's hash-ready strobe. The captured digest is presented to a downstream consumer over a second valid/ready handshake. It sits between a byte source (UART, DMA, test harness) and the SHA top level, driving the SHA top level's Data/Enable inputs and consuming its Hash/Ready outputs.

---
 rtl/sha_stream_if.sv | 38 +++
 rtl/sha_stream.sv | 146 ++++++++++++++
 tb/tb_sha_stream.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_stream_if.sv
// Handshake bundle for sha_stream: byte input, SHA core start/result, and digest output.
// The block itself uses the slave modport; the surrounding system uses the master modport.
interface sha_stream_if #(
    parameter int Nl = 64,
    parameter int Nk = 256
);
    logic [7:0]    In_Data;
    logic          In_Valid;
    logic          In_Last;
    logic          In_Ready;

    logic [7:0]    Sha_Data [0:Nl-1];
    logic          Sha_Enable;
    logic [Nk-1:0] Sha_Hash;
    logic          Sha_Ready;

    logic [Nk-1:0] Out_Hash;
    logic          Out_Valid;
    logic          Out_Ready;

    modport slave (
        input  In_Data, In_Valid, In_Last,
        output In_Ready,
        output Sha_Data, Sha_Enable,
        input  Sha_Hash, Sha_Ready,
        output Out_Hash, Out_Valid,
        input  Out_Ready
    );

    modport master (
        output In_Data, In_Valid, In_Last,
        input  In_Ready,
        input  Sha_Data, Sha_Enable,
        output Sha_Hash, Sha_Ready,
        input  Out_Hash, Out_Valid,
        output Out_Ready
    );
endinterface

// File: rtl/sha_stream.sv
// Byte-stream front end for the SHA core: packs bytes into an Nl-byte buffer, starts the core, returns the digest.
// Optional result watchdog compiled in with SHA_STREAM_TIMEOUT_EN.
module sha_stream #(
    parameter int Nl = 64,
    parameter int Nk = 256,
    parameter int Nt = 4096
) (
    input  logic        clk,
    input  logic        rst,
    sha_stream_if.slave bus,
    output logic        Error
);

    localparam int CW = $clog2(Nl + 1);

    typedef enum logic [1:0] {
        LOAD,
        START,
        WAIT,
        OUTPUT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic [7:0]    buffer [0:Nl-1];
    logic [Nk-1:0] out_hash;
    logic          run_en;

    logic          in_ready;
    logic          accept;
    logic          msg_end;
    logic          hash_take;
    logic          out_take;
    logic          wd_expire;
    logic          clear_buf;

    if (Nl < 1 || Nt < 2) begin : g_cfg_check
        $error("sha_stream: Nl must be at least 1 and Nt at least 2");
    end

`ifdef SHA_STREAM_TIMEOUT_EN
    localparam int WW = $clog2(Nt);
    logic [WW-1:0] wd_count;
`endif

    // run_en keeps In_Ready low while reset is held and through the release cycle,
    // without giving In_Ready a combinational path from the reset pin.
    assign in_ready       = (state == LOAD) && run_en;
    assign bus.In_Ready   = in_ready;
    assign bus.Sha_Enable = (state == START);
    assign bus.Out_Valid  = (state == OUTPUT);
    assign bus.Out_Hash   = out_hash;
    assign bus.Sha_Data   = buffer;

    assign accept    = bus.In_Valid && in_ready;
    assign msg_end   = accept && (bus.In_Last || (count == CW'(Nl - 1)));
    assign clear_buf = out_take || wd_expire;

    always_comb begin
        state_nxt = state;
        hash_take = 1'b0;
        out_take  = 1'b0;
        wd_expire = 1'b0;
        case (state)
            LOAD: begin
                if (msg_end) state_nxt = START;
            end
            START: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.Sha_Ready) begin
                    hash_take = 1'b1;
                    state_nxt = OUTPUT;
                end
`ifdef SHA_STREAM_TIMEOUT_EN
                else if (wd_count == WW'(Nt - 1)) begin
                    wd_expire = 1'b1;
                    state_nxt = LOAD;
                end
`endif
            end
            OUTPUT: begin
                if (bus.Out_Ready) begin
                    out_take  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= LOAD;
            run_en   <= 1'b0;
            count    <= '0;
            out_hash <= '0;
        end else begin
            state  <= state_nxt;
            run_en <= 1'b1;
            if (clear_buf) begin
                count <= '0;
            end else if (accept) begin
                count <= count + CW'(1);
            end
            if (hash_take) begin
                out_hash <= bus.Sha_Hash;
            end
        end
    end

    // Unwritten positions stay zero, so short messages arrive zero-filled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Nl; i++) buffer[i] <= 8'h00;
        end else begin
            for (int i = 0; i < Nl; i++) begin
                if (clear_buf) begin
                    buffer[i] <= 8'h00;
                end else if (accept && (count == CW'(i))) begin
                    buffer[i] <= bus.In_Data;
                end
            end
        end
    end

`ifdef SHA_STREAM_TIMEOUT_EN
    // Cleared while in START so the first WAIT cycle counts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_count <= '0;
        end else if (state == START) begin
            wd_count <= '0;
        end else if (state == WAIT) begin
            wd_count <= wd_count + WW'(1);
        end
    end

    assign Error = wd_expire;
`else
    assign Error = 1'b0;
`endif

endmodule

// File: tb/tb_sha_stream.sv
// Randomized scoreboard bench for sha_stream with a behavioural SHA-core responder.
module tb_sha_stream;

    localparam int NL = 64;
    localparam int NK = 256;
    localparam int KW = NL * 8;
`ifdef SHA_STREAM_TIMEOUT_EN
    localparam int NT = 16;
`else
    localparam int NT = 4096;
`endif

    typedef struct packed {
        logic [KW-1:0] b;
        logic [NK-1:0] h;
    } exp_t;

    typedef struct packed {
        int            lat;
        logic [NK-1:0] h;
    } sha_t;

    typedef logic [7:0] bq_t [$];

    logic clk;
    logic rst;
    logic err;

    sha_stream_if #(.Nl(NL), .Nk(NK)) bus ();

    sha_stream #(.Nl(NL), .Nk(NK), .Nt(NT)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .Error (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   ph = 0;
    int   nb = 0;
    int   hs_cyc = -1;
    int   err_due = -1;
    int   en_cnt = 0;
    int   stall_left = 0;
    bit   or_rand = 1'b0;
    bit   sha_busy = 1'b0;
    exp_t exp_q [$];
    sha_t sha_q [$];

    task automatic chk1(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b want %b", name, cyc, act, req);
        end
    endtask

    task automatic chkw(input string name, input logic [KW-1:0] act, input logic [KW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, req);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s cycle %0d: event missing", name, cyc);
    endtask

    function automatic logic [KW-1:0] sha_data_now();
        logic [KW-1:0] p;
        for (int i = 0; i < NL; i++) p[8*i +: 8] = bus.Sha_Data[i];
        return p;
    endfunction

    // Scoreboard monitor: tracks the message protocol and checks every cycle.
    initial begin
        exp_t cur;
        logic err_exp;
        cur = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                chk1("rst_in_ready", bus.In_Ready, 1'b0);
                chk1("rst_out_valid", bus.Out_Valid, 1'b0);
                chk1("rst_sha_enable", bus.Sha_Enable, 1'b0);
                chkw("rst_out_hash", KW'(bus.Out_Hash), '0);
                ph = 0; nb = 0; hs_cyc = -1; err_due = -1;
            end else begin
                err_exp = 1'b0;
`ifdef SHA_STREAM_TIMEOUT_EN
                if (ph == 2 && cyc == err_due && !bus.Sha_Ready) err_exp = 1'b1;
`endif
                chk1("error", err, err_exp);
                if (hs_cyc >= 0 && cyc == hs_cyc + 1) begin
                    chk1("ready_after_out", bus.In_Ready, 1'b1);
                    chkw("buf_cleared", sha_data_now(), '0);
                end
                if (ph != 0) chk1("in_ready_busy", bus.In_Ready, 1'b0);
                if (ph != 1) chk1("enable_idle", bus.Sha_Enable, 1'b0);
                if (ph != 3) chk1("out_valid_idle", bus.Out_Valid, 1'b0);
                case (ph)
                    0: begin
                        if (bus.In_Valid && bus.In_Ready) begin
                            nb++;
                            if (bus.In_Last || nb == NL) begin
                                ph = 1;
                                nb = 0;
                            end
                        end
                    end
                    1: begin
                        chk1("enable_pulse", bus.Sha_Enable, 1'b1);
                        if (exp_q.size() == 0) fail("exp_queue");
                        else begin
                            cur = exp_q.pop_front();
                            chkw("sha_data", sha_data_now(), cur.b);
                        end
                        en_cnt++;
                        err_due = cyc + NT;
                        ph = 2;
                    end
                    2: begin
                        if (bus.Sha_Ready) ph = 3;
                        else if (err_exp) begin
                            ph = 0;
                            hs_cyc = cyc;
                        end
                    end
                    default: begin
                        chk1("out_valid", bus.Out_Valid, 1'b1);
                        chkw("out_hash", KW'(bus.Out_Hash), KW'(cur.h));
                        if (bus.Out_Valid && bus.Out_Ready) begin
                            chkw("sha_data_held", sha_data_now(), cur.b);
                            ph = 0;
                            hs_cyc = cyc;
                        end
                    end
                endcase
            end
        end
    end

    // Behavioural SHA core: answers each start pulse after the queued latency.
    initial begin
        sha_t s;
        bus.Sha_Ready = 1'b0;
        bus.Sha_Hash  = {8{$urandom}};
        forever begin
            @(negedge clk);
            if (rst && bus.Sha_Enable && sha_q.size() != 0) begin
                s = sha_q.pop_front();
                if (s.lat > 0) begin
                    sha_busy = 1'b1;
                    repeat (s.lat) @(posedge clk);
                    #2;
                    bus.Sha_Ready = 1'b1;
                    bus.Sha_Hash  = s.h;
                    @(posedge clk);
                    #2;
                    bus.Sha_Ready = 1'b0;
                    bus.Sha_Hash  = {8{$urandom}};
                    sha_busy = 1'b0;
                end
            end
        end
    end

    // Digest consumer: optional forced stall, otherwise always-ready or random.
    initial begin
        bus.Out_Ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (stall_left > 0) begin
                bus.Out_Ready = 1'b0;
                if (bus.Out_Valid) stall_left--;
            end else begin
                bus.Out_Ready = or_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit last);
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        bus.In_Data  = b;
        bus.In_Valid = 1'b1;
        bus.In_Last  = last;
        while (!done) begin
            @(negedge clk);
            if (bus.In_Ready) done = 1'b1;
            @(posedge clk);
            #2;
            n++;
            if (!done && n > 2000) begin
                fail("byte_accept_timeout");
                $fatal(1, "byte never accepted");
            end
        end
    endtask

    task automatic send_msg(input bq_t m, input bit last, input int lat,
                            input logic [NK-1:0] h, input int gap);
        exp_t e;
        sha_t s;
        e.b = '0;
        e.h = h;
        for (int i = 0; i < m.size(); i++) e.b[8*i +: 8] = m[i];
        s.lat = lat;
        s.h   = h;
        exp_q.push_back(e);
        sha_q.push_back(s);
        for (int i = 0; i < m.size(); i++) begin
            send_byte(m[i], last && (i == m.size() - 1));
            if (gap > 0 && i != m.size() - 1) begin
                int k;
                k = $urandom_range(0, gap);
                if (k > 0) begin
                    bus.In_Valid = 1'b0;
                    bus.In_Last  = 1'($urandom_range(0, 1));
                    bus.In_Data  = 8'($urandom);
                    repeat (k) @(posedge clk);
                    #2;
                end
            end
        end
        bus.In_Valid = 1'b0;
        bus.In_Last  = 1'($urandom_range(0, 1));
        bus.In_Data  = 8'($urandom);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((ph != 0 || exp_q.size() != 0 || sha_busy) && n < limit) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (n >= limit) fail("drain_timeout");
    endtask

    function automatic bq_t rand_msg(input int len);
        bq_t q;
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        bq_t m;
        int  base;
        int  n;
        int  len;

        rst          = 1'b0;
        bus.In_Valid = 1'b1;
        bus.In_Data  = 8'h55;
        bus.In_Last  = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst          = 1'b1;
        bus.In_Valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk1("ready_after_reset", bus.In_Ready, 1'b1);
        chkw("no_capture_in_reset", sha_data_now(), '0);
        @(posedge clk);
        #2;

        // Full 64-byte block, no In_Last, fixed 10-cycle core latency.
        m = {};
        for (int i = 0; i < NL; i++) m.push_back(8'(i));
        send_msg(m, 1'b0, 10, {32{8'hA5}}, 0);
        drain(500);

        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b1, 4, {8{$urandom}}, 0);
        drain(500);

        // Digest held for 20 cycles while the next message is already offered.
        stall_left = 20;
        send_msg(rand_msg(7), 1'b1, 3, {8{$urandom}}, 0);
        send_msg(rand_msg(3), 1'b1, 2, {8{$urandom}}, 0);
        drain(500);

        // Reset while waiting on the core; its late result must be ignored.
        base = en_cnt;
        send_msg(rand_msg(9), 1'b1, 10, {8{$urandom}}, 0);
        n = 0;
        while (en_cnt == base && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) fail("enable_for_reset_test");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        drain(100);
        repeat (3) @(posedge clk);
        #2;
        chkw("buf_after_wait_reset", sha_data_now(), '0);
        chk1("out_valid_after_wait_reset", bus.Out_Valid, 1'b0);

`ifdef SHA_STREAM_TIMEOUT_EN
        send_msg(rand_msg(5), 1'b1, -1, {8{$urandom}}, 0);
        drain(100);
`endif

        or_rand = 1'b1;
        for (int t = 0; t < 25; t++) begin
            len = $urandom_range(1, NL);
            send_msg(rand_msg(len), (len < NL) ? 1'b1 : 1'($urandom_range(0, 1)),
                     $urandom_range(1, 12), {8{$urandom}}, 3);
        end
        drain(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
